// File: rtl/host_cmd_if.sv
// Host command front end: assembles 64-bit GEMM commands from two register writes,
// checks their lengths, queues them in an issue FIFO and tracks issue/completion.
module host_cmd_if #(
  parameter int ADDR_WIDTH           = 10,
  parameter int SYSTOLIC_ARRAY_WIDTH = 16,
  parameter int FIFO_DEPTH           = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [4:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  output logic        cmd_valid,
  output logic [63:0] cmd_data,
  input  logic        cmd_ready,
  input  logic        core_busy,
  input  logic        core_done,
  output logic        irq
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 1;
  localparam int USED = 24 + 4 * ADDR_WIDTH;
  localparam logic [63:0] CMD_MASK = (USED >= 64) ? {64{1'b1}} : ((64'd1 << USED) - 64'd1);
  localparam logic [7:0]  MAX_LEN  = 8'(SYSTOLIC_ARRAY_WIDTH);

  localparam logic [4:0] A_CMD_LO   = 5'h00;
  localparam logic [4:0] A_CMD_HI   = 5'h04;
  localparam logic [4:0] A_STATUS   = 5'h08;
  localparam logic [4:0] A_IRQ_STAT = 5'h0C;
  localparam logic [4:0] A_IRQ_EN   = 5'h10;
  localparam logic [4:0] A_ISSUED   = 5'h14;
  localparam logic [4:0] A_DONE     = 5'h18;

  logic [31:0]   cmd_lo;
  logic [63:0]   push_word;
  logic          push_vld;
  logic [63:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   issued_cnt, done_cnt;
  logic [2:0]    irq_stat, irq_en;

  logic          wr_access, rd_access, hi_write, lens_ok;
  logic          full, pop, push, overflow_set;
  logic [63:0]   new_word;
  logic [2:0]    w1c_mask, set_mask;
  logic [31:0]   rd_val;

  function automatic logic len_ok(input logic [7:0] len);
    return (len != 8'd0) && (len <= MAX_LEN);
  endfunction

  assign wr_access = bus_req & bus_we;
  assign rd_access = bus_req & ~bus_we;
  assign hi_write  = wr_access && (bus_addr == A_CMD_HI);
  assign new_word  = {bus_wdata, cmd_lo} & CMD_MASK;
  assign lens_ok   = len_ok(new_word[7:0]) & len_ok(new_word[15:8]) & len_ok(new_word[23:16]);

  assign cmd_valid    = (count != '0);
  assign cmd_data     = mem[rd_ptr];
  assign full         = (count == CW'(FIFO_DEPTH));
  assign pop          = cmd_valid & cmd_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge
  assign push         = push_vld & (~full | pop);
  assign overflow_set = push_vld & full & ~pop;

  assign w1c_mask = (wr_access && (bus_addr == A_IRQ_STAT)) ? bus_wdata[2:0] : 3'b000;
  assign set_mask = {hi_write & ~lens_ok, overflow_set, core_done};

  always_comb begin
    rd_val = '0;
    case (bus_addr)
      A_STATUS: begin
        rd_val[0]    = core_busy | cmd_valid;
        rd_val[1]    = full;
        rd_val[7:4]  = 4'(count);
        rd_val[23:8] = issued_cnt[15:0] - done_cnt[15:0];
      end
      A_IRQ_STAT: rd_val[2:0] = irq_stat;
      A_IRQ_EN:   rd_val[2:0] = irq_en;
      A_ISSUED:   rd_val      = issued_cnt;
      A_DONE:     rd_val      = done_cnt;
      default:    rd_val      = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_ack   <= 1'b0;
      bus_rdata <= '0;
      cmd_lo    <= '0;
      irq_en    <= '0;
      push_vld  <= 1'b0;
      push_word <= '0;
    end else begin
      bus_ack   <= bus_req;
      bus_rdata <= rd_access ? rd_val : '0;
      if (wr_access && (bus_addr == A_CMD_LO)) cmd_lo <= bus_wdata;
      if (wr_access && (bus_addr == A_IRQ_EN)) irq_en <= bus_wdata[2:0];
      // One staging register so the word reaches the FIFO on the edge after the ack
      push_vld <= hi_write & lens_ok;
      if (hi_write) push_word <= new_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_word;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_cnt <= '0;
      done_cnt   <= '0;
      irq_stat   <= '0;
      irq        <= 1'b0;
    end else begin
      if (pop)       issued_cnt <= issued_cnt + 32'd1;
      if (core_done) done_cnt   <= done_cnt + 32'd1;
      irq_stat <= (irq_stat & ~w1c_mask) | set_mask;
      irq      <= |(irq_stat & irq_en);
    end
  end

endmodule
